// File: rtl/rx_cmd_assembler.sv
// rx_cmd_assembler: collects tagged UART frames into operand/opcode registers and
// issues the completed command to the ALU over a valid/ready handshake.
// Reports unknown tags, frames dropped while a command is pending, and stale
// partial commands discarded by the inter-frame timeout.
// Optional: define RX_CMD_ASSEMBLER_ERR_CNT_EN to add saturating error counters on o_err_cnt.
module rx_cmd_assembler #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TAG_W          = 2,
   parameter int unsigned NUM_OPERANDS   = 2,
   parameter int unsigned OPCODE_TAG     = 2,
   parameter int unsigned OP_W           = 6,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [DATA_W+TAG_W-1:0]        i_rx_data,
   input  logic                           i_rx_done,
   input  logic                           i_ready,
   output logic                           o_valid,
   output logic [NUM_OPERANDS*DATA_W-1:0] o_operands,
   output logic [OP_W-1:0]                o_opcode,
   output logic                           o_tag_err,
   output logic                           o_overrun,
   output logic                           o_timeout
`ifdef RX_CMD_ASSEMBLER_ERR_CNT_EN
   ,
   output logic [23:0]                    o_err_cnt
`endif
);

   localparam int unsigned FrameW = DATA_W + TAG_W;
   localparam int unsigned MaskW  = NUM_OPERANDS + 1;
   localparam int unsigned CntW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TAG_W-1:0] OpcTag  = TAG_W'(OPCODE_TAG);
   localparam logic [CntW-1:0]  CntLast = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic {StCollect, StIssue} state_e;

   state_e                           state_q, state_d;
   logic [NUM_OPERANDS*DATA_W-1:0]   operands_q, operands_d;
   logic [OP_W-1:0]                  opcode_q, opcode_d;
   logic [MaskW-1:0]                 mask_q, mask_d;
   logic [CntW-1:0]                  cnt_q, cnt_d;
   logic                             tag_err_q, tag_err_d;
   logic                             overrun_q, overrun_d;
   logic                             timeout_q, timeout_d;

   logic [TAG_W-1:0]  tag;
   logic [DATA_W-1:0] payload;
   logic              tag_hit;

   assign tag     = i_rx_data[FrameW-1:DATA_W];
   assign payload = i_rx_data[DATA_W-1:0];

   // Next-state: frame decode, completion, handshake, overrun and timeout.
   always_comb begin
      state_d    = state_q;
      operands_d = operands_q;
      opcode_d   = opcode_q;
      mask_d     = mask_q;
      cnt_d      = cnt_q;
      tag_err_d  = 1'b0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
      tag_hit    = 1'b0;
      unique case (state_q)
         StCollect: begin
            if (i_rx_done) begin
               // A received frame always beats a coincident terminal count.
               cnt_d = '0;
               for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
                  if (tag == TAG_W'(k)) begin
                     operands_d[k*DATA_W +: DATA_W] = payload;
                     mask_d[k]                      = 1'b1;
                     tag_hit                        = 1'b1;
                  end
               end
               if (!tag_hit) begin
                  if (tag == OpcTag) begin
                     opcode_d             = payload[OP_W-1:0];
                     mask_d[NUM_OPERANDS] = 1'b1;
                  end else begin
                     tag_err_d = 1'b1;
                  end
               end
               if (&mask_d) begin
                  state_d = StIssue;
               end
            end else if ((TIMEOUT_CYCLES != 0) && (mask_q != '0)) begin
               if (cnt_q == CntLast) begin
                  mask_d    = '0;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StIssue: begin
            // Frames arriving while a command is pending are dropped.
            if (i_rx_done) begin
               overrun_d = 1'b1;
            end
            if (i_ready) begin
               state_d = StCollect;
               mask_d  = '0;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= StCollect;
         operands_q <= '0;
         opcode_q   <= '0;
         mask_q     <= '0;
         cnt_q      <= '0;
         tag_err_q  <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         operands_q <= operands_d;
         opcode_q   <= opcode_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         tag_err_q  <= tag_err_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_valid    = (state_q == StIssue);
   assign o_operands = operands_q;
   assign o_opcode   = opcode_q;
   assign o_tag_err  = tag_err_q;
   assign o_overrun  = overrun_q;
   assign o_timeout  = timeout_q;

`ifdef RX_CMD_ASSEMBLER_ERR_CNT_EN
   logic [7:0] tag_err_cnt_q, overrun_cnt_q, timeout_cnt_q;

   // Saturating per-event error counters, stepped by the registered pulses.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         tag_err_cnt_q <= '0;
         overrun_cnt_q <= '0;
         timeout_cnt_q <= '0;
      end else begin
         if (tag_err_q && (tag_err_cnt_q != 8'hFF)) tag_err_cnt_q <= tag_err_cnt_q + 8'd1;
         if (overrun_q && (overrun_cnt_q != 8'hFF)) overrun_cnt_q <= overrun_cnt_q + 8'd1;
         if (timeout_q && (timeout_cnt_q != 8'hFF)) timeout_cnt_q <= timeout_cnt_q + 8'd1;
      end
   end

   assign o_err_cnt = {timeout_cnt_q, overrun_cnt_q, tag_err_cnt_q};
`endif

endmodule

// File: tb/tb_rx_cmd_assembler.sv
// Directed bench for rx_cmd_assembler: a two-operand instance with a short timeout
// and a three-operand instance, both driven #1 after the rising edge and sampled there.
module tb_rx_cmd_assembler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default shape, timeout shortened to 100 cycles.
   logic [9:0]  a_data = '0;
   logic        a_done = 1'b0, a_ready = 1'b0;
   logic        a_valid, a_tag_err, a_overrun, a_timeout;
   logic [15:0] a_operands;
   logic [5:0]  a_opcode;
`ifdef RX_CMD_ASSEMBLER_ERR_CNT_EN
   logic [23:0] a_err_cnt, b_err_cnt;
`endif

   // Instance B: three operands, opcode on tag 3.
   logic [9:0]  b_data = '0;
   logic        b_done = 1'b0, b_ready = 1'b0;
   logic        b_valid, b_tag_err, b_overrun, b_timeout;
   logic [23:0] b_operands;
   logic [5:0]  b_opcode;

   rx_cmd_assembler #(.TIMEOUT_CYCLES(100)) u_dut_a (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_rx_data  (a_data),
      .i_rx_done  (a_done),
      .i_ready    (a_ready),
      .o_valid    (a_valid),
      .o_operands (a_operands),
      .o_opcode   (a_opcode),
      .o_tag_err  (a_tag_err),
      .o_overrun  (a_overrun),
      .o_timeout  (a_timeout)
`ifdef RX_CMD_ASSEMBLER_ERR_CNT_EN
      ,
      .o_err_cnt  (a_err_cnt)
`endif
   );

   rx_cmd_assembler #(.NUM_OPERANDS(3), .OPCODE_TAG(3), .TIMEOUT_CYCLES(100)) u_dut_b (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_rx_data  (b_data),
      .i_rx_done  (b_done),
      .i_ready    (b_ready),
      .o_valid    (b_valid),
      .o_operands (b_operands),
      .o_opcode   (b_opcode),
      .o_tag_err  (b_tag_err),
      .o_overrun  (b_overrun),
      .o_timeout  (b_timeout)
`ifdef RX_CMD_ASSEMBLER_ERR_CNT_EN
      ,
      .o_err_cnt  (b_err_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [9:0] frame);
      a_data = frame;
      a_done = 1'b1;
      step();
      a_done = 1'b0;
   endtask

   task automatic send_b(input logic [9:0] frame);
      b_data = frame;
      b_done = 1'b1;
      step();
      b_done = 1'b0;
   endtask

   initial begin
      int early;
      step();
      check_eq("reset_valid", 32'(a_valid), 32'd0);
      check_eq("reset_operands", 32'(a_operands), 32'h0);
      check_eq("reset_pulses", {29'd0, a_tag_err, a_overrun, a_timeout}, 32'd0);
      rst_n = 1'b1;
      step();

      // Basic command: two operands then opcode.
      send_a(10'h055);
      send_a(10'h1F5);
      check_eq("not_valid_before_opcode", 32'(a_valid), 32'd0);
      send_a(10'h220);
      check_eq("valid_latency1", 32'(a_valid), 32'd1);
      check_eq("operands_basic", 32'(a_operands), 32'hF555);
      check_eq("opcode_basic", 32'(a_opcode), 32'h20);
      a_ready = 1'b1;
      step();
      check_eq("valid_drop_after_hs", 32'(a_valid), 32'd0);
      a_ready = 1'b0;

      // Unknown tag pulses once and does not disturb collection.
      send_a(10'h055);
      send_a(10'h3AA);
      check_eq("tag_err_pulse", 32'(a_tag_err), 32'd1);
      step();
      check_eq("tag_err_one_cycle", 32'(a_tag_err), 32'd0);
      send_a(10'h1F5);
      send_a(10'h220);
      check_eq("valid_after_tag_err", 32'(a_valid), 32'd1);
      check_eq("operands_after_tag_err", 32'(a_operands), 32'hF555);
      a_ready = 1'b1;
      step();
      a_ready = 1'b0;

      // Overrun while a command is pending.
      send_a(10'h055);
      send_a(10'h1F5);
      send_a(10'h220);
      check_eq("valid_pending", 32'(a_valid), 32'd1);
      send_a(10'h011);
      check_eq("overrun_pulse", 32'(a_overrun), 32'd1);
      check_eq("operands_hold_overrun", 32'(a_operands), 32'hF555);
      check_eq("opcode_hold_overrun", 32'(a_opcode), 32'h20);
      check_eq("valid_hold_overrun", 32'(a_valid), 32'd1);
      step();
      check_eq("overrun_one_cycle", 32'(a_overrun), 32'd0);
      a_ready = 1'b1;
      step();
      check_eq("valid_drop_after_overrun", 32'(a_valid), 32'd0);

      // Ready already high: handshake on the first valid cycle.
      send_a(10'h0AA);
      send_a(10'h1BB);
      send_a(10'h203);
      check_eq("early_ready_valid", 32'(a_valid), 32'd1);
      check_eq("early_ready_operands", 32'(a_operands), 32'hBBAA);
      step();
      check_eq("early_ready_drop", 32'(a_valid), 32'd0);
      a_ready = 1'b0;

      // Timeout: 100 idle cycles after a partial load.
      send_a(10'h055);
      early = 0;
      for (int i = 0; i < 99; i++) begin
         step();
         if (a_timeout) early++;
      end
      check_eq("no_early_timeout", 32'(early), 32'd0);
      step();
      check_eq("timeout_pulse", 32'(a_timeout), 32'd1);
      step();
      check_eq("timeout_one_cycle", 32'(a_timeout), 32'd0);
      send_a(10'h1F5);
      send_a(10'h220);
      check_eq("no_valid_after_timeout", 32'(a_valid), 32'd0);
      send_a(10'h055);
      check_eq("valid_after_reload", 32'(a_valid), 32'd1);

`ifdef RX_CMD_ASSEMBLER_ERR_CNT_EN
      check_eq("err_cnt", 32'(a_err_cnt), 32'h010101);
`endif

      // Reset while issuing drops valid without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_valid", 32'(a_valid), 32'd0);
      check_eq("async_reset_operands", 32'(a_operands), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      send_a(10'h220);
      check_eq("no_valid_after_reset", 32'(a_valid), 32'd0);

      // Three-operand instance.
      send_b(10'h001);
      send_b(10'h102);
      send_b(10'h203);
      check_eq("b_not_valid_before_opcode", 32'(b_valid), 32'd0);
      send_b(10'h321);
      check_eq("b_valid", 32'(b_valid), 32'd1);
      check_eq("b_operands", 32'(b_operands), 32'h030201);
      check_eq("b_opcode", 32'(b_opcode), 32'h21);
      b_ready = 1'b1;
      step();
      check_eq("b_valid_drop", 32'(b_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
